// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment readout.
// Contents:
//   SEG_TABLE     16-entry active-high pattern table (gfedcba), 10-15 show a dash
//   SEG_BLANK     all segments off
//   SEG_DASH      segment g only
//   state_t       conversion FSM states
//   pow10         constant function, 10**n
//   guard_nibbles constant function, extra BCD nibbles needed above the displayed digits
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;

   // Digit 9 deliberately leaves segment d dark to match the board artwork.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1100111,  // 9
      7'b1000000,  // 10..15 cannot be produced by the converter; show a dash
      7'b1000000,
      7'b1000000,
      7'b1000000,
      7'b1000000,
      7'b1000000
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic longint pow10(input int n);
      longint p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   // Zero when every IN_WIDTH value fits in the displayed digits; otherwise the
   // number of decimal digits of 2**in_width-1 (floor(n*log10(2))+1) beyond them.
   function automatic int guard_nibbles(input int in_width, input int num_digits,
                                        input longint p10);
      int need;
      need = (in_width * 30103) / 100000 + 1;
      if ((in_width < 62) && ((longint'(1) << in_width) <= p10)) begin
         return 0;
      end else if (need > num_digits) begin
         return need - num_digits;
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational encoder for one seven-segment digit.
// Ports:
//   digit      in  4  BCD digit to show
//   blank      in  1  force all segments off (wins over dash)
//   dash       in  1  show segment g only
//   active_low in  1  invert the final pattern (0 = lit)
//   segs       out 7  segment pattern, bit order gfedcba
module seg7_encode
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   input  logic       active_low,
   output logic [6:0] segs
);

   logic [6:0] lit_s;

   // Pick the active-high pattern: blank, then dash, then the digit glyph.
   always_comb begin
      lit_s = SEG_BLANK;
      if (blank) begin
         lit_s = SEG_BLANK;
      end else if (dash) begin
         lit_s = SEG_DASH;
      end else begin
         lit_s = SEG_TABLE[digit];
      end
   end

   // Polarity is applied last so blank and dash invert consistently.
   assign segs = active_low ? ~lit_s : lit_s;

endmodule

// File: rtl/bcd_seg_display.sv
// Multi-digit decimal readout: sequential double-dabble conversion of an
// unsigned binary value, then per-digit seven-segment encoding with
// leading-zero blanking, overflow dashes and blinking.
// Ports:
//   clk        in  1             system clock
//   rst        in  1             synchronous reset, active-high
//   load       in  1             start a conversion of value (accepted only when idle)
//   value      in  IN_WIDTH      unsigned value to display
//   blink_en   in  1             enable blinking
//   blink_tick in  1             strobe that toggles the blink phase
//   busy       out 1             conversion in progress
//   done       out 1             one-cycle pulse when segs/overflow take the new result
//   overflow   out 1             last value did not fit in NUM_DIGITS digits
//   segs       out 7*NUM_DIGITS  digit k at [7k+6:7k], digit 0 = ones, gfedcba
module bcd_seg_display
   import seg_pkg::*;
#(
   parameter int IN_WIDTH   = 8,
   parameter int NUM_DIGITS = 3,
   parameter int ACTIVE_LOW = 1,
   parameter int BLANK_LZ   = 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [IN_WIDTH-1:0]     value,
   input  logic                    blink_en,
   input  logic                    blink_tick,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] segs
);

   localparam longint POW10      = pow10(NUM_DIGITS);
   localparam int     GUARD      = guard_nibbles(IN_WIDTH, NUM_DIGITS, POW10);
   localparam int     BCD_DIGITS = NUM_DIGITS + GUARD;
   localparam int     BCD_W      = 4 * BCD_DIGITS;
   localparam int     DISP_W     = 4 * NUM_DIGITS;
   localparam int     WORK_W     = BCD_W + IN_WIDTH;
   localparam int     CNT_W      = (IN_WIDTH < 2) ? 1 : $clog2(IN_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

   state_t                    state_r;
   state_t                    state_next_s;
   logic [IN_WIDTH-1:0]       bin_r;
   logic [BCD_W-1:0]          bcd_r;
   logic [CNT_W-1:0]          cnt_r;
   logic [BCD_W-1:0]          adj_s;
   logic [WORK_W-1:0]         work_s;
   logic [BCD_W-1:0]          bcd_shift_s;
   logic [IN_WIDTH-1:0]       bin_shift_s;
   logic                      guard_nz_s;
   logic                      busy_r;
   logic                      done_r;
   logic                      ovf_r;
   logic                      phase_r;
   logic [DISP_W-1:0]         digits_r;
   logic [DISP_W-1:0]         digits_next_s;
   logic                      ovf_next_s;
   logic                      phase_next_s;
   logic [7*NUM_DIGITS-1:0]   enc_s;
   logic [7*NUM_DIGITS-1:0]   segs_r;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load) begin
               state_next_s = ST_SHIFT;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == LAST_CNT) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_SHIFT;
            end
         end
         ST_DONE:  state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Add-3 correction on every nibble that would overflow past 9 when doubled.
   always_comb begin
      adj_s = bcd_r;
      for (int k = 0; k < BCD_DIGITS; k++) begin
         if (bcd_r[4*k +: 4] >= 4'd5) begin
            adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
         end else begin
            adj_s[4*k +: 4] = bcd_r[4*k +: 4];
         end
      end
   end

   // The top BCD bit drops out of the shift; it is always zero given the guard sizing.
   assign work_s = {adj_s, bin_r} << 1'b1;
   assign bcd_shift_s = work_s[WORK_W-1:IN_WIDTH];
   assign bin_shift_s = work_s[IN_WIDTH-1:0];

   if (GUARD > 0) begin : g_guard
      assign guard_nz_s = |bcd_shift_s[BCD_W-1:DISP_W];
   end else begin : g_no_guard
      assign guard_nz_s = 1'b0;
   end

   // Conversion datapath: capture on load, shift once per SHIFT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_r <= '0;
         bcd_r <= '0;
         cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (load) begin
                  bin_r <= value;
                  bcd_r <= '0;
                  cnt_r <= '0;
               end
            end
            ST_SHIFT: begin
               bin_r <= bin_shift_s;
               bcd_r <= bcd_shift_s;
               cnt_r <= cnt_r + CNT_W'(1);
            end
            default: begin
               bin_r <= bin_r;
               bcd_r <= bcd_r;
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Next displayed state. The result is taken straight from the final shift
   // so the registered segs change in the same cycle done is high.
   always_comb begin
      digits_next_s = digits_r;
      ovf_next_s    = ovf_r;
      phase_next_s  = phase_r;
      if (rst) begin
         digits_next_s = '0;
         ovf_next_s    = 1'b0;
         phase_next_s  = 1'b0;
      end else begin
         if ((state_r == ST_SHIFT) && (state_next_s == ST_DONE)) begin
            digits_next_s = bcd_shift_s[DISP_W-1:0];
            ovf_next_s    = guard_nz_s;
         end else begin
            digits_next_s = digits_r;
            ovf_next_s    = ovf_r;
         end
         if (!blink_en) begin
            phase_next_s = 1'b0;
         end else if (blink_tick) begin
            phase_next_s = ~phase_r;
         end else begin
            phase_next_s = phase_r;
         end
      end
   end

   // One encoder per digit; digit 0 is never blanked as a leading zero.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      logic lz_s;
      if (k == 0) begin : g_lsd
         assign lz_s = 1'b0;
      end else begin : g_hi
         assign lz_s = (BLANK_LZ != 0) && (digits_next_s[DISP_W-1:4*k] == '0);
      end
      seg7_encode u_enc (
         .digit      (digits_next_s[4*k +: 4]),
         .blank      (phase_next_s | (lz_s & ~ovf_next_s)),
         .dash       (ovf_next_s),
         .active_low (ACTIVE_LOW != 0),
         .segs       (enc_s[7*k +: 7])
      );
   end

   // Status, latched result and registered segment outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         digits_r <= '0;
         ovf_r    <= 1'b0;
         phase_r  <= 1'b0;
      end else begin
         busy_r   <= (state_next_s != ST_IDLE);
         done_r   <= (state_next_s == ST_DONE);
         digits_r <= digits_next_s;
         ovf_r    <= ovf_next_s;
         phase_r  <= phase_next_s;
      end
      segs_r <= enc_s;
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign overflow = ovf_r;
   assign segs     = segs_r;

endmodule

// File: tb/tb_bcd_seg_display.sv
module tb_bcd_seg_display;

   localparam logic [6:0] P_BLK  = 7'b1111111;
   localparam logic [6:0] P_0    = 7'b1000000;
   localparam logic [6:0] P_1    = 7'b1111001;
   localparam logic [6:0] P_2    = 7'b0100100;
   localparam logic [6:0] P_4    = 7'b0011001;
   localparam logic [6:0] P_5    = 7'b0010010;
   localparam logic [6:0] P_7    = 7'b1111000;
   localparam logic [6:0] P_9    = 7'b0011000;
   localparam logic [6:0] P_DASH = 7'b0111111;

   logic        clk;
   logic        rst;
   logic        load;
   logic [7:0]  value;
   logic        blink_en;
   logic        blink_tick;

   logic        busy_a, done_a, ovf_a;
   logic [20:0] segs_a;
   logic        busy_b, done_b, ovf_b;
   logic [13:0] segs_b;
   logic        busy_c, done_c, ovf_c;
   logic [20:0] segs_c;

   int n_total = 0;
   int n_bad   = 0;

   // Main instance: 3 digits, leading-zero blanking.
   bcd_seg_display #(.IN_WIDTH(8), .NUM_DIGITS(3), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut_a (
      .clk(clk), .rst(rst), .load(load), .value(value), .blink_en(blink_en),
      .blink_tick(blink_tick), .busy(busy_a), .done(done_a), .overflow(ovf_a), .segs(segs_a));

   // Two-digit instance, exercises the overflow path.
   bcd_seg_display #(.IN_WIDTH(8), .NUM_DIGITS(2), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut_b (
      .clk(clk), .rst(rst), .load(load), .value(value), .blink_en(blink_en),
      .blink_tick(blink_tick), .busy(busy_b), .done(done_b), .overflow(ovf_b), .segs(segs_b));

   // Three digits without leading-zero blanking.
   bcd_seg_display #(.IN_WIDTH(8), .NUM_DIGITS(3), .ACTIVE_LOW(1), .BLANK_LZ(0)) u_dut_c (
      .clk(clk), .rst(rst), .load(load), .value(value), .blink_en(blink_en),
      .blink_tick(blink_tick), .busy(busy_c), .done(done_c), .overflow(ovf_c), .segs(segs_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a one-cycle load, then wait (bounded) for done on the main instance.
   task automatic run_load(input logic [7:0] v, output int cycles);
      value = v;
      load  = 1'b1;
      step();
      load  = 1'b0;
      cycles = 1;
      while (!done_a && cycles < 30) begin
         step();
         cycles++;
      end
   endtask

   int cyc;
   int pulses;

   initial begin
      rst = 1'b1; load = 1'b0; value = 8'd0; blink_en = 1'b0; blink_tick = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state.
      check_val("rst_busy", 32'(busy_a), 32'd0);
      check_val("rst_done", 32'(done_a), 32'd0);
      check_val("rst_ovf", 32'(ovf_a), 32'd0);
      check_val("rst_segs_a", 32'(segs_a), 32'({P_BLK, P_BLK, P_0}));
      check_val("rst_segs_b", 32'(segs_b), 32'({P_BLK, P_0}));
      check_val("rst_segs_c", 32'(segs_c), 32'({P_0, P_0, P_0}));

      // 255: latency, hold of old digits during conversion, result.
      value = 8'd255;
      load  = 1'b1;
      step();
      load  = 1'b0;
      check_val("busy_t1", 32'(busy_a), 32'd1);
      check_val("hold_segs_t1", 32'(segs_a), 32'({P_BLK, P_BLK, P_0}));
      cyc = 1;
      while (!done_a && cyc < 30) begin
         step();
         cyc++;
         if (!done_a && cyc < 9) begin
            check_val("hold_segs", 32'(segs_a), 32'({P_BLK, P_BLK, P_0}));
         end
      end
      check_val("lat_255", 32'(cyc), 32'd9);
      check_val("busy_done", 32'(busy_a), 32'd1);
      check_val("segs_255", 32'(segs_a), 32'({P_2, P_5, P_5}));
      check_val("ovf_255", 32'(ovf_a), 32'd0);
      check_val("ovf_255_b", 32'(ovf_b), 32'd1);
      check_val("segs_255_b", 32'(segs_b), 32'({P_DASH, P_DASH}));
      step();
      check_val("done_pulse_end", 32'(done_a), 32'd0);
      check_val("busy_end", 32'(busy_a), 32'd0);

      // 7: blanking versus no blanking.
      run_load(8'd7, cyc);
      check_val("done_7", 32'(done_a), 32'd1);
      check_val("segs_7", 32'(segs_a), 32'({P_BLK, P_BLK, P_7}));
      check_val("segs_7_nolz", 32'(segs_c), 32'({P_0, P_0, P_7}));
      check_val("segs_7_b", 32'(segs_b), 32'({P_BLK, P_7}));
      check_val("ovf_7_b", 32'(ovf_b), 32'd0);
      step();

      // 100: overflow on the two-digit display.
      run_load(8'd100, cyc);
      check_val("ovf_100_b", 32'(ovf_b), 32'd1);
      check_val("segs_100_b", 32'(segs_b), 32'({P_DASH, P_DASH}));
      check_val("segs_100", 32'(segs_a), 32'({P_1, P_0, P_0}));
      step();

      // 99: just fits in two digits.
      run_load(8'd99, cyc);
      check_val("ovf_99_b", 32'(ovf_b), 32'd0);
      check_val("segs_99_b", 32'(segs_b), 32'({P_9, P_9}));
      step();

      // 42, with a second load while busy that must be dropped.
      value = 8'd42;
      load  = 1'b1;
      step();
      load  = 1'b0;
      step();
      step();
      value = 8'd13;
      load  = 1'b1;
      step();
      load  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         if (done_a) pulses++;
         step();
      end
      check_val("one_done_42", 32'(pulses), 32'd1);
      check_val("segs_42", 32'(segs_a), 32'({P_BLK, P_4, P_2}));
      check_val("busy_42_idle", 32'(busy_a), 32'd0);

      // Blinking with a tick every 4 cycles.
      blink_en = 1'b1;
      step();
      check_val("blink_en_vis", 32'(segs_a), 32'({P_BLK, P_4, P_2}));
      for (int r = 0; r < 2; r++) begin
         blink_tick = 1'b1;
         step();
         blink_tick = 1'b0;
         check_val("blink_off", 32'(segs_a), 32'h1F_FFFF);
         step(); step(); step();
         check_val("blink_off_hold", 32'(segs_a), 32'h1F_FFFF);
         blink_tick = 1'b1;
         step();
         blink_tick = 1'b0;
         check_val("blink_on", 32'(segs_a), 32'({P_BLK, P_4, P_2}));
         step(); step(); step();
      end
      blink_tick = 1'b1;
      step();
      blink_tick = 1'b0;
      check_val("blink_off_b", 32'(segs_b), 32'h3FFF);
      blink_en = 1'b0;
      step();
      check_val("blink_drop", 32'(segs_a), 32'({P_BLK, P_4, P_2}));

      // 0 converts normally.
      run_load(8'd0, cyc);
      check_val("lat_0", 32'(cyc), 32'd9);
      check_val("segs_0", 32'(segs_a), 32'({P_BLK, P_BLK, P_0}));
      step();

      // 42 again so the reset below has something to clear.
      run_load(8'd42, cyc);
      step();

      // Reset 4 cycles into a conversion of 200.
      value = 8'd200;
      load  = 1'b1;
      step();
      load  = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("abort_busy", 32'(busy_a), 32'd0);
      check_val("abort_done", 32'(done_a), 32'd0);
      check_val("abort_segs", 32'(segs_a), 32'({P_BLK, P_BLK, P_0}));
      check_val("abort_segs_c", 32'(segs_c), 32'({P_0, P_0, P_0}));
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         if (done_a) pulses++;
         step();
      end
      check_val("abort_no_done", 32'(pulses), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
